// File: rtl/burst_reader.sv
// burst_reader: debug-bus slave that fetches one 4x64-bit read burst from the
// burst bus and serves it to the host one octet at a time through register 4.
// Optional build macro: BURST_READER_PREFETCH_EN -- when defined, draining the
// last octet immediately requests the next burst at mem_addr + 8.
//
// state | meaning
// IDLE  | no burst outstanding, buffer empty
// REQ   | read command presented, waiting for mem_ready
// FILL  | command accepted, collecting read beats
// VALID | buffer full, host draining octets

module burst_reader #(
    parameter int         BURST_WORDS = 4,
    parameter logic [7:0] CHIP_PAGE   = 8'h0b
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dbus_addr,
    input  logic        dbus_write_enable,
    input  logic [7:0]  dbus_write_data,
    input  logic        dbus_read_enable,
    output logic [7:0]  dbus_read_data,
    output logic [20:0] mem_addr,
    output logic        mem_cmd,
    output logic        mem_cmd_en,
    input  logic        mem_ready,
    input  logic [63:0] mem_rd_data,
    input  logic        mem_rd_data_valid
);

    typedef enum logic [1:0] {IDLE, REQ, FILL, VALID} state_t;

    localparam logic [1:0] LAST_WORD = 2'(BURST_WORDS - 1);

    state_t      state, state_nxt;
    logic [63:0] buffer [BURST_WORDS];
    logic [4:0]  rd_ptr;
    logic [1:0]  word_cnt;
    logic        underrun;

    logic        sel;
    logic [4:0]  reg_sel;
    logic        addr_wr;
    logic        start;
    logic        rd_octet;
    logic        pop;
    logic        last_pop;
    logic        beat;
    logic        last_beat;
    logic [63:0] cur_word;
    logic [7:0]  rd_val;
    logic        unused_ok;

    assign mem_cmd   = 1'b0;
    assign unused_ok = &{1'b0, dbus_addr[7:5]};

    // Access decode: address writes are only accepted while no burst is in flight.
    always_comb begin
        sel       = (dbus_addr[15:8] == CHIP_PAGE);
        reg_sel   = dbus_addr[4:0];
        addr_wr   = sel && dbus_write_enable && (state == IDLE || state == VALID);
        start     = addr_wr && (reg_sel == 5'd3);
        rd_octet  = sel && dbus_read_enable && (reg_sel == 5'd4);
        pop       = rd_octet && (state == VALID);
        last_pop  = pop && (rd_ptr == 5'd31);
        beat      = (state == FILL) && mem_rd_data_valid;
        last_beat = beat && (word_cnt == LAST_WORD);
    end

    // Next-state logic; mem_cmd_en is decoded from state so reset drops it at once.
    always_comb begin
        state_nxt  = state;
        mem_cmd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = REQ;
            end
            REQ: begin
                mem_cmd_en = 1'b1;
                if (mem_ready)
                    state_nxt = FILL;
            end
            FILL: begin
                if (last_beat)
                    state_nxt = VALID;
            end
            VALID: begin
                if (start)
                    state_nxt = REQ;
                else if (last_pop)
`ifdef BURST_READER_PREFETCH_EN
                    state_nxt = REQ;
`else
                    state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux: octets leave MSB-first, so octet k of a word sits at bit 8*(7-k).
    always_comb begin
        cur_word = buffer[rd_ptr[4:3]];
        rd_val   = 8'h00;
        case (reg_sel)
            5'd4: if (state == VALID) rd_val = 8'(cur_word >> {~rd_ptr[2:0], 3'b000});
            5'd5: rd_val = {5'b0, underrun, (state == REQ || state == FILL), (state == VALID)};
            default: rd_val = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Address, pointer, beat counter, sticky underrun and registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr       <= '0;
            rd_ptr         <= '0;
            word_cnt       <= '0;
            underrun       <= 1'b0;
            dbus_read_data <= '0;
        end else begin
            if (beat)
                word_cnt <= word_cnt + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 5'd1;
            if (last_pop)
                mem_addr <= mem_addr + 21'd8;
            if (rd_octet && state != VALID)
                underrun <= 1'b1;
            if (addr_wr) begin
                case (reg_sel)
                    5'd1: mem_addr[20:16] <= dbus_write_data[4:0];
                    5'd2: mem_addr[15:8]  <= dbus_write_data;
                    5'd3: begin
                        mem_addr[7:0] <= dbus_write_data;
                        rd_ptr        <= '0;
                        word_cnt      <= '0;
                        underrun      <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (sel && dbus_read_enable)
                dbus_read_data <= rd_val;
        end
    end

    // Beat storage carries no reset; its contents are meaningless outside VALID.
    always_ff @(posedge clk) begin
        if (beat)
            buffer[word_cnt] <= mem_rd_data;
    end

endmodule
